mux_n_1_reg: RTL

//  Parametrised N-input, W-bit registered multiplexer with valid/ready handshake on every port.

---
 rtl/mux_pkg.sv | 12 +
 rtl/rr_arbiter_n.sv | 37 +++
 rtl/mux_n_1_reg.sv | 95 +++++++++
 3 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 multiplexer family.
package mux_pkg;

   localparam int MUX_MODE_SEL = 0;
   localparam int MUX_MODE_RR  = 1;

   // Never returns 0, so a select bus always has at least one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin grant: rotate requests so ptr sits at bit 0, then take the lowest set bit.
module rr_arbiter_n
   import mux_pkg::*;
#(
   parameter int N    = 4,
   parameter int SELW = clog2_min1(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   output logic [SELW-1:0] gnt_idx,
   output logic            gnt_valid
);

   localparam logic [SELW:0] NVAL = (SELW+1)'(N);

   logic [N-1:0] rot;
   logic [SELW:0] idx;

   // Scanning downwards lets the nearest requester after ptr win.
   always_comb begin
      rot       = N'({req, req} >> ptr);
      idx       = '0;
      gnt_idx   = '0;
      gnt_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            idx = {1'b0, ptr} + (SELW+1)'(k);
            if (idx >= NVAL) begin
               idx = idx - NVAL;
            end
            gnt_idx   = idx[SELW-1:0];
            gnt_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_n_1_reg.sv
// N-input registered multiplexer with valid/ready on every port; selects by sel
// (MODE=0) or round-robin over in_valid (MODE=1), one word per cycle.
module mux_n_1_reg
   import mux_pkg::*;
#(
   parameter int N    = 4,
   parameter int W    = 32,
   parameter int SELW = clog2_min1(N),
   parameter int MODE = MUX_MODE_SEL
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N*W-1:0]  in_data,
   input  logic [N-1:0]    in_valid,
   output logic [N-1:0]    in_ready,
   input  logic [SELW-1:0] sel,
   output logic [W-1:0]    out_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [SELW-1:0] out_src
);

   logic            load_en;
   logic            xfer;
   logic [SELW-1:0] grant;
   logic            grant_valid;
   logic [W-1:0]    pick;

   assign load_en = !out_valid || out_ready;
   assign xfer    = rst_n && load_en && grant_valid;

   generate
      if (MODE == MUX_MODE_RR) begin : g_rr
         logic [SELW-1:0] rr_ptr;

         rr_arbiter_n #(
            .N    (N),
            .SELW (SELW)
         ) u_arb (
            .req       (in_valid),
            .ptr       (rr_ptr),
            .gnt_idx   (grant),
            .gnt_valid (grant_valid)
         );

         // The pointer only moves past a channel once it has actually delivered a word.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               rr_ptr <= '0;
            end else if (xfer) begin
               rr_ptr <= (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
            end
         end
      end else begin : g_sel
         // An out-of-range sel matches no channel and so grants nothing.
         always_comb begin
            grant       = '0;
            grant_valid = 1'b0;
            for (int i = 0; i < N; i++) begin
               if (sel == SELW'(i) && in_valid[i]) begin
                  grant       = SELW'(i);
                  grant_valid = 1'b1;
               end
            end
         end
      end
   endgenerate

   always_comb begin
      pick     = '0;
      in_ready = '0;
      for (int i = 0; i < N; i++) begin
         if (grant == SELW'(i)) begin
            pick = in_data[i*W +: W];
         end
         in_ready[i] = xfer && (grant == SELW'(i));
      end
   end

   // A drain without a new grant clears valid but keeps data/src for observability.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_src   <= '0;
      end else if (xfer) begin
         out_valid <= 1'b1;
         out_data  <= pick;
         out_src   <= grant;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule
